mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 32, data/address width; BURST_MAX, 4, max consecutive locked grants to one port (range 2..15).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request from port 0 (CPU) / port 1 (loader/DMA).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-006 adr0, adr1, wd0, wd1  input  WIDTH each  address / write data; valid while reqN high.
REQ-007 lock0, lock1  input  1 each  request to keep ownership for the next access.
REQ-008 gnt0, gnt1  output  1 each  command accepted this cycle; combinational, one-hot or zero.
REQ-009 rdata0, rdata1  output  WIDTH each  registered read data.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse; rdataN valid.
REQ-011 memread, memwrite  output  1 each  memory strobes, registered, never both high.
REQ-012 adr, writedata  output  WIDTH each  registered memory address / write data.
REQ-013 memdata  input  WIDTH  memory read data, valid the cycle after memread.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACC, RD; gntN SHALL assert only in IDLE.
REQ-016 IDLE: if any reqN, assert the winner's gntN. At that edge, capture adrN/wdN/weN into adr/writedata, record owner, go to ACC. With no request, remain in IDLE.
REQ-017 ACC: memwrite=1 if captured we, else memread=1, for exactly one cycle; write -> IDLE, read -> RD.
REQ-018 RD: capture memdata into rdata[owner]; pulse rvalid[owner] the following cycle; -> IDLE.
REQ-019 Latency: gnt at cycle T; strobe at T+1; read data at T+2; rvalid at T+3; write returns to IDLE at T+2.
REQ-020 Requester holds reqN and its command until gntN; reqN high in the cycle after gntN is a new request.
REQ-021 Lock: if the owner had lockN=1 when granted and the locked-grant count is below BURST_MAX, the owner wins the next IDLE arbitration if it requests. Otherwise normal arbitration applies.
REQ-022 Locked-grant counter (4 bits): increments on each consecutive locked grant to the same owner. It clears on an unlocked grant, on an owner change, or when it reaches BURST_MAX. Clearing at BURST_MAX forces normal arbitration for that grant.
REQ-023 If the lock holder does not request in IDLE, the lock is released, the counter clears and the other port may win.
REQ-024 rdata0/rdata1 hold their values until the next read completion for that port.
REQ-025 adr/writedata hold their last captured values when idle.

Reset
REQ-026 On reset sampled high, at that edge: state=IDLE, memread=memwrite=0, adr=writedata=0, rdata0=rdata1=0, rvalid0=rvalid1=0, counter=0, last-grant pointer=1 (port 0 favoured next).
REQ-027 Reset in ACC or RD aborts the access: no rvalid is produced for it, and strobes are low from the cycle after reset is sampled.
REQ-028 gnt0/gnt1 SHALL be 0 while reset is high.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: on a simultaneous unlocked conflict, grant the port not granted last; the pointer updates on every grant.
REQ-030 MEM_ARB_ROUND_ROBIN_EN undefined: on conflict, port 0 always wins; lock behaviour is unchanged; no pointer register exists.

Verification
REQ-031 Single read: req0=1, we0=0, adr0=0x40, memory[0x40]=0xDEADBEEF -> gnt0 at T, memread with adr=0x40 at T+1, rvalid0 with rdata0=0xDEADBEEF at T+3.
REQ-032 Single write: req1=1, we1=1, adr1=0x10, wd1=0x5 -> gnt1 at T, memwrite with writedata=0x5 at T+1, busy=0 at T+2.
REQ-033 Conflict: req0 and req1 held continuously with writes -> with the macro, grants alternate 0,1,0,1; without the macro, gnt0 every grant and gnt1 never.
REQ-034 Burst lock: req0=lock0=1 and req1=1 held, BURST_MAX=4, macro defined -> four consecutive gnt0, then gnt1.
REQ-035 Reset mid-read: reset asserted in the RD cycle -> no rvalid0, memread=0, busy=0 the next cycle; a fresh req0 is granted in the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grant, one-cycle strobe, registered read return, lock bursts.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise port 0 always wins.
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  input  logic             lock0,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  output logic             busy
);

  // state | meaning
  // IDLE  | arbitrate; grant and capture the winner's command
  // ACC   | drive memread or memwrite for one cycle
  // RD    | capture memdata for the owner; rvalid follows
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RD = 2'd2} state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] adr_q, adr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             memread_q, memread_d, memwrite_q, memwrite_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic             win_any, win, lock_win, req_owner, lock_hold;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  // cnt_q != 0 means the previous grant was locked by owner_q
  always_comb begin
    req_owner = owner_q ? req1 : req0;
    lock_hold = (cnt_q != 4'd0) && (cnt_q < BMAX) && req_owner;
    win_any   = (state_q == IDLE) && !reset && (req0 || req1);
    if (lock_hold) begin
      win = owner_q;
    end else if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = ~last_q;
`else
      win = 1'b0;
`endif
    end else begin
      win = !req0;
    end
    lock_win = win ? lock1 : lock0;
  end

  assign gnt0 = win_any && !win;
  assign gnt1 = win_any && win;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cnt_q != 4'd0 && !req_owner) cnt_d = 4'd0;
        if (win_any) begin
          owner_d    = win;
          we_d       = win ? we1 : we0;
          adr_d      = win ? adr1 : adr0;
          wdata_d    = win ? wd1 : wd0;
          memwrite_d = we_d;
          memread_d  = !we_d;
          state_d    = ACC;
          if (cnt_q >= BMAX)                         cnt_d = 4'd0;
          else if (!lock_win)                        cnt_d = 4'd0;
          else if (win == owner_q && cnt_q != 4'd0)  cnt_d = cnt_q + 4'd1;
          else                                       cnt_d = 4'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = win;
`endif
        end
      end
      ACC: state_d = we_q ? IDLE : RD;
      RD: begin
        if (owner_q) begin
          rdata1_d  = memdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = memdata;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 4'd0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign adr       = adr_q;
  assign writedata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level timeline model (grant -> strobe/return events scheduled ahead).
module tb_mem_arbiter;
  localparam int W    = 32;
  localparam int BMAX = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req0, req1, we0, we1, lock0, lock1;
  logic [W-1:0] adr0, adr1, wd0, wd1;
  logic gnt0, gnt1, rvalid0, rvalid1, memread, memwrite, busy;
  logic [W-1:0] rdata0, rdata1, adr, writedata, memdata;

  mem_arbiter #(.WIDTH(W), .BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .busy(busy)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign memdata = mem_f(adr);

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // timeline model state
  int          free_at, streak, holder, last;
  logic [31:0] cur_adr, cur_wd;
  logic [31:0] held [2];
  logic        sch_mr [8];
  logic        sch_mw [8];
  int          sch_rv [8];
  logic [31:0] sch_rd [8];
  logic        eg [2];

  // random driver state
  logic        pend [2];
  logic        c_we [2];
  logic        c_lk [2];
  logic [31:0] c_adr [2];
  logic [31:0] c_wd [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_init();
    free_at = 0; streak = 0; holder = 0; last = 1;
    cur_adr = '0; cur_wd = '0; held[0] = '0; held[1] = '0;
    for (int k = 0; k < 8; k++) begin
      sch_mr[k] = 1'b0; sch_mw[k] = 1'b0; sch_rv[k] = 0; sch_rd[k] = '0;
    end
    eg[0] = 1'b0; eg[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  task automatic model_step();
    int s;
    int win;
    bit idle;
    bit wr;
    logic [1:0] rq;
    logic [1:0] lk;
    s   = cyc % 8;
    win = -1;
    rq  = {req1, req0};
    lk  = {lock1, lock0};
    if (sch_rv[s] != 0) held[sch_rv[s]-1] = sch_rd[s];
    idle = (cyc >= free_at);
    if (!reset && idle && rq != 2'b00) begin
      if (streak > 0 && streak < BMAX && rq[holder]) win = holder;
      else if (rq == 2'b11) win = RR ? 1 - last : 0;
      else win = rq[0] ? 0 : 1;
    end
    check_val("gnt0",      32'(gnt0),     32'(win == 0));
    check_val("gnt1",      32'(gnt1),     32'(win == 1));
    check_val("busy",      32'(busy),     32'(!idle));
    check_val("memread",   32'(memread),  32'(sch_mr[s]));
    check_val("memwrite",  32'(memwrite), 32'(sch_mw[s]));
    check_val("rvalid0",   32'(rvalid0),  32'(sch_rv[s] == 1));
    check_val("rvalid1",   32'(rvalid1),  32'(sch_rv[s] == 2));
    check_val("rdata0",    rdata0,        held[0]);
    check_val("rdata1",    rdata1,        held[1]);
    check_val("adr",       adr,           cur_adr);
    check_val("writedata", writedata,     cur_wd);
    sch_mr[s] = 1'b0; sch_mw[s] = 1'b0; sch_rv[s] = 0;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        sch_mr[k] = 1'b0; sch_mw[k] = 1'b0; sch_rv[k] = 0;
      end
      free_at = cyc + 1; cur_adr = '0; cur_wd = '0;
      held[0] = '0; held[1] = '0; streak = 0; last = 1;
    end else if (idle) begin
      if (streak > 0 && !rq[holder]) streak = 0;
      if (win >= 0) begin
        if (streak >= BMAX) streak = 0;
        else if (lk[win]) begin
          streak = (win == holder && streak > 0) ? streak + 1 : 1;
          holder = win;
        end else streak = 0;
        last    = win;
        cur_adr = (win == 1) ? adr1 : adr0;
        cur_wd  = (win == 1) ? wd1 : wd0;
        wr      = (win == 1) ? we1 : we0;
        if (wr) begin
          sch_mw[(cyc+1)%8] = 1'b1;
          free_at = cyc + 2;
        end else begin
          sch_mr[(cyc+1)%8] = 1'b1;
          sch_rv[(cyc+3)%8] = win + 1;
          sch_rd[(cyc+3)%8] = mem_f(cur_adr);
          free_at = cyc + 3;
        end
      end
    end
    eg[0] = (win == 0);
    eg[1] = (win == 1);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: random traffic with occasional reset; 1: held writes, no lock; 2: held writes, port 0 locked
  task automatic drive_rand(input int mode);
    for (int p = 0; p < 2; p++) begin
      if (eg[p]) pend[p] = 1'b0;
      if (!pend[p] && (mode != 0 || $urandom_range(0, 1) == 1)) begin
        pend[p]  = 1'b1;
        c_we[p]  = (mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        c_adr[p] = $urandom;
        c_wd[p]  = $urandom;
        if (mode == 2)      c_lk[p] = (p == 0);
        else if (mode == 1) c_lk[p] = 1'b0;
        else                c_lk[p] = ($urandom_range(0, 2) == 0);
      end
    end
    reset = (mode == 0) && ($urandom_range(0, 149) == 0);
    req0 = pend[0]; we0 = c_we[0]; adr0 = c_adr[0]; wd0 = c_wd[0]; lock0 = c_lk[0];
    req1 = pend[1]; we1 = c_we[1]; adr1 = c_adr[1]; wd1 = c_wd[1]; lock1 = c_lk[1];
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0; adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    model_init();
    cycle();
    reset = 1'b0;

    // single read from port 0
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h40;
    cycle();
    req0 = 1'b0;
    repeat (4) cycle();

    // single write from port 1
    req1 = 1'b1; we1 = 1'b1; adr1 = 32'h10; wd1 = 32'h5;
    cycle();
    req1 = 1'b0;
    repeat (3) cycle();

    // reset during the RD cycle, then a fresh request
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h80;
    cycle();
    req0 = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; req0 = 1'b1; adr0 = 32'h40;
    cycle();
    req0 = 1'b0;
    repeat (4) cycle();

    // continuous write conflict
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (40) begin drive_rand(1); cycle(); end

    // locked burst from port 0 against port 1, from a clean reset
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cycle();
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (60) begin drive_rand(2); cycle(); end

    // random traffic
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (2000) begin drive_rand(0); cycle(); end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
